// File: rtl/vect_rep_ser.sv
// Purpose: buffers pixel vectors (2 entries) and emits each channel value REPEAT_NUM times, channel-outer, with line/frame markers.
// Latency: a vector accepted into an empty buffer while idle shows its first word 2 cycles later; IN_CH_NUM*REPEAT_NUM words per pixel.
// Backpressure: ready_o is registered and drops while 2 vectors are buffered; the output side has no backpressure.
module vect_rep_ser #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_CH_NUM  = 8,
  parameter int REPEAT_NUM = 3,
  parameter int STRING_LEN = 224
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [DATA_WIDTH*IN_CH_NUM-1:0] data_i,
  input  logic                           sop_i,
  input  logic                           eop_i,
  input  logic                           sof_i,
  input  logic                           eof_i,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           valid_o,
  output logic                           sop_o,
  output logic                           eop_o,
  output logic                           sof_o,
  output logic                           eof_o,
  output logic                           err_o
);

  localparam int CH_W  = (IN_CH_NUM  > 1) ? $clog2(IN_CH_NUM)  : 1;
  localparam int REP_W = (REPEAT_NUM > 1) ? $clog2(REPEAT_NUM) : 1;
  localparam int PIX_W = $clog2(STRING_LEN + 2);
  localparam int PW1   = PIX_W + 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(IN_CH_NUM - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_NUM - 1);
  localparam logic [PIX_W:0]   LEN_W    = PW1'(STRING_LEN);
  localparam logic [PIX_W:0]   LEN_SAT  = PW1'(STRING_LEN + 1);

  typedef struct packed {
    logic                            sop;
    logic                            eop;
    logic                            sof;
    logic                            eof;
    logic [DATA_WIDTH*IN_CH_NUM-1:0] vec;
  } entry_t;

  typedef enum logic {IDLE, SER} state_t;

  entry_t            buf_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q, occ_d;
  logic              ready_q;
  state_t            state_q;
  logic [CH_W-1:0]   ch_cnt_q;
  logic [REP_W-1:0]  rep_cnt_q;
  logic [PIX_W-1:0]  pix_cnt_q;
  logic [PIX_W:0]    pix_nxt;
  logic              err_q;
  logic              push, pop, first_word, last_word;
  entry_t            head;
  logic [DATA_WIDTH-1:0] head_ch;

  assign push       = valid_i & ready_q;
  assign first_word = (ch_cnt_q == '0) && (rep_cnt_q == '0);
  assign last_word  = (ch_cnt_q == CH_LAST) && (rep_cnt_q == REP_LAST);
  assign pop        = (state_q == SER) && last_word;
  assign head       = buf_q[rd_ptr_q];
  assign ready_o    = ready_q;
  assign err_o      = err_q;

  // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
  always_comb begin
    occ_d = occ_q;
    if (push && !pop) occ_d = occ_q + 2'd1;
    else if (!push && pop) occ_d = occ_q - 2'd1;
  end

  // Select the current channel of the head vector.
  always_comb begin
    head_ch = '0;
    for (int i = 0; i < IN_CH_NUM; i++) begin
      if (ch_cnt_q == CH_W'(i)) head_ch = head.vec[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Pixel count as it would be after accepting the presented pixel.
  always_comb begin
    pix_nxt = sop_i ? PW1'(1) : ({1'b0, pix_cnt_q} + PW1'(1));
  end

  // Two-entry vector buffer with registered ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= '{sop: sop_i, eop: eop_i, sof: sof_i, eof: eof_i, vec: data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q   <= occ_d;
      ready_q <= (occ_d != 2'd2);
    end
  end

  // Serializer FSM with registered outputs; chains straight into the next vector when one is waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ch_cnt_q  <= '0;
      rep_cnt_q <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      sop_o     <= 1'b0;
      eop_o     <= 1'b0;
      sof_o     <= 1'b0;
      eof_o     <= 1'b0;
    end else begin
      data_o  <= '0;
      valid_o <= 1'b0;
      sop_o   <= 1'b0;
      eop_o   <= 1'b0;
      sof_o   <= 1'b0;
      eof_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (occ_q != 2'd0) begin
            ch_cnt_q  <= '0;
            rep_cnt_q <= '0;
            state_q   <= SER;
          end
        end
        SER: begin
          valid_o <= 1'b1;
          data_o  <= head_ch;
          sop_o   <= head.sop & first_word;
          sof_o   <= head.sof & first_word;
          eop_o   <= head.eop & last_word;
          eof_o   <= head.eof & last_word;
          if (rep_cnt_q == REP_LAST) begin
            rep_cnt_q <= '0;
            if (ch_cnt_q == CH_LAST) begin
              ch_cnt_q <= '0;
              if (occ_d == 2'd0) state_q <= IDLE;
            end else begin
              ch_cnt_q <= ch_cnt_q + CH_W'(1);
            end
          end else begin
            rep_cnt_q <= rep_cnt_q + REP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line-length check on accepted pixels; the count saturates just past the line length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt_q <= '0;
      err_q     <= 1'b0;
    end else if (push) begin
      pix_cnt_q <= (pix_nxt > LEN_W) ? LEN_SAT[PIX_W-1:0] : pix_nxt[PIX_W-1:0];
      if (eop_i ? (pix_nxt != LEN_W) : (pix_nxt > LEN_W)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vect_rep_ser.sv
// Bench for vect_rep_ser: randomized vectors, expected word stream queued per accepted pixel,
// monitor pops and compares every output cycle; line-length error tracked by a small pixel-count model.
module tb_vect_rep_ser;

  localparam int DW  = 8;
  localparam int CH  = 8;
  localparam int REP = 3;
  localparam int LEN = 224;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid_i;
  logic          ready_o;
  logic [DW*CH-1:0] data_i;
  logic          sop_i, eop_i, sof_i, eof_i;
  logic [DW-1:0] data_o;
  logic          valid_o, sop_o, eop_o, sof_o, eof_o, err_o;

  vect_rep_ser #(.DATA_WIDTH(DW), .IN_CH_NUM(CH), .REPEAT_NUM(REP), .STRING_LEN(LEN)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
    .data_o(data_o), .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o),
    .sof_o(sof_o), .eof_o(eof_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic sop, eop, sof, eof;
  } word_t;

  word_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    model_cnt = 0;
  logic  exp_err = 1'b0;
  int    words_seen = 0;
  int    run_len = 0;
  int    last_run = 0;
  bit    saw_not_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: compares every output cycle against the queued expectations.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("err_o", {31'd0, err_o}, {31'd0, exp_err});
      if (valid_o === 1'b1) begin
        run_len++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got data %0h with no word pending", data_o);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("data_o", {24'd0, data_o}, {24'd0, w.d});
          chk("markers", {28'd0, sop_o, eop_o, sof_o, eof_o}, {28'd0, w.sop, w.eop, w.sof, w.eof});
          words_seen++;
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        chk("idle_outputs", {19'd0, data_o, sop_o, eop_o, sof_o, eof_o}, 32'd0);
      end
    end
  end

  // Reference: each accepted pixel becomes CH*REP words, channel-outer, repeat-inner.
  task automatic model_accept(input logic [DW*CH-1:0] v, input logic s, e, sf, ef);
    word_t w;
    for (int c = 0; c < CH; c++) begin
      for (int r = 0; r < REP; r++) begin
        w.d   = v[c*DW +: DW];
        w.sop = s  && (c == 0) && (r == 0);
        w.sof = sf && (c == 0) && (r == 0);
        w.eop = e  && (c == CH-1) && (r == REP-1);
        w.eof = ef && (c == CH-1) && (r == REP-1);
        exp_q.push_back(w);
      end
    end
    model_cnt = s ? 1 : model_cnt + 1;
    if (e ? (model_cnt != LEN) : (model_cnt > LEN)) exp_err = 1'b1;
  endtask

  // Present a pixel and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [DW*CH-1:0] v, input logic s, e, sf, ef);
    bit acc;
    @(negedge clk);
    data_i = v; sop_i = s; eop_i = e; sof_i = sf; eof_i = ef; valid_i = 1'b1;
    acc = 0;
    for (int n = 0; n < 200; n++) begin
      acc = ready_o;
      if (!acc) saw_not_ready = 1;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    if (acc) model_accept(v, s, e, sf, ef);
    else begin
      total++;
      bad++;
      $display("FAIL send_timeout: ready_o stayed %0b for 200 cycles", ready_o);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin done = 1; break; end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d words still pending", exp_q.size());
    end
    repeat (4) @(posedge clk);
  endtask

  function automatic logic [DW*CH-1:0] rand_vec();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int lat;
    int base;
    reset_n = 1'b0; valid_i = 1'b0; data_i = '0;
    sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ready_o}, 32'd0);
    chk("reset_outputs", {18'd0, data_o, valid_o, sop_o, eop_o, sof_o, eof_o, err_o}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", {31'd0, ready_o}, 32'd1);

    // 1: single known vector, latency and marker placement
    send(64'h0807060504030201, 1'b1, 1'b0, 1'b1, 1'b0);
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      valid_i = 1'b0; sop_i = 1'b0; sof_i = 1'b0;
      if (valid_o) break;
      @(posedge clk);
      lat++;
    end
    chk("first_word_latency", lat, 32'd2);
    wait_drain();
    chk("run_len_single", last_run, 32'd24);

    // 2: three back-to-back random vectors, gapless output and backpressure
    saw_not_ready = 0;
    for (int i = 0; i < 3; i++) send(rand_vec(), 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    wait_drain();
    chk("backpressure_seen", {31'd0, saw_not_ready}, 32'd1);
    chk("run_len_three", last_run, 32'd72);

    // 3: full legal line, eop/eof on the last pixel, random input gaps
    for (int p = 0; p < LEN; p++) begin
      send(rand_vec(), p == 0, p == LEN-1, p == 0, p == LEN-1);
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    wait_drain();
    chk("err_full_line", {31'd0, err_o}, 32'd0);

    // 4: short line, eop on the 5th pixel
    send(rand_vec(), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int p = 1; p < 4; p++) send(rand_vec(), 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("err_before_short_eop", {31'd0, err_o}, 32'd0);
    send(rand_vec(), 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("err_after_short_eop", {31'd0, err_o}, 32'd1);
    idle();
    wait_drain();
    chk("err_sticky", {31'd0, err_o}, 32'd1);

    // 5: reset during word 10 of a pixel
    base = words_seen;
    send(rand_vec(), 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (words_seen >= base + 9) break;
    end
    @(negedge clk);
    #1;
    chk("word10_reached", words_seen - base, 32'd10);
    reset_n = 1'b0;
    #1;
    chk("outputs_in_reset", {18'd0, data_o, valid_o, sop_o, eop_o, sof_o, eof_o, err_o}, 32'd0);
    chk("ready_in_reset", {31'd0, ready_o}, 32'd0);
    exp_q.delete();
    exp_err = 1'b0;
    model_cnt = 0;
    run_len = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rereset", {31'd0, ready_o}, 32'd1);
    repeat (30) @(posedge clk);
    send(64'h1122334455667788, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    wait_drain();

    // 6: extreme signed values
    send(64'h7F80807F7F80807F, 1'b0, 1'b0, 1'b0, 1'b0);
    send(64'h807F807F807F807F, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    wait_drain();
    chk("run_len_extremes", last_run, 32'd48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
